uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses 4-byte register-write frames (SYNC, ADDR, DATA, CHK)
// from a UART byte stream. The checksum is the 8-bit wrapped sum of SYNC, ADDR
// and DATA.
// Optional macro UART_CMD_TIMEOUT_EN enables the inter-byte timeout; with it
// undefined the parser waits indefinitely for the next byte.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CLKS = 21700,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       osc_clk,
    input  logic       i_Rst,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Err,
    output logic [7:0] o_Err_Count,
    output logic       o_Busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_ADDR = 2'd1,
        GET_DATA = 2'd2,
        GET_CHK  = 2'd3
    } state_t;

    // A timeout shorter than two cycles could never be reached between bytes
    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 2");
    end

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wr_en_d, err_d;
    logic [7:0] wr_addr_d, wr_data_d, err_cnt_d;
    logic       tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Expiry only counts when no byte arrives in the same cycle
    assign tmo_hit = (state_q != IDLE) && !i_Rx_DV &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CLKS - 1));

    // Inter-byte cycle counter, cleared by every byte and while idle
    always_ff @(posedge osc_clk or posedge i_Rst) begin
        if (i_Rst) begin
            tmo_cnt_q <= '0;
        end else if (i_Rx_DV || (state_q == IDLE)) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Busy is a pure decode of the state register
    assign o_Busy = (state_q != IDLE);

    // State, latched fields and registered outputs
    always_ff @(posedge osc_clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            o_Wr_En     <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= '0;
            o_Err       <= 1'b0;
            o_Err_Count <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            o_Wr_En     <= wr_en_d;
            o_Wr_Addr   <= wr_addr_d;
            o_Wr_Data   <= wr_data_d;
            o_Err       <= err_d;
            o_Err_Count <= err_cnt_d;
        end
    end

    // Next-state, field capture, checksum compare and error counting
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        wr_addr_d = o_Wr_Addr;
        wr_data_d = o_Wr_Data;
        err_d     = 1'b0;
        err_cnt_d = o_Err_Count;

        if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (i_Rx_DV) begin
            case (state_q)
                IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        state_d = GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    addr_d  = i_Rx_Byte;
                    state_d = GET_DATA;
                end
                GET_DATA: begin
                    data_d  = i_Rx_Byte;
                    state_d = GET_CHK;
                end
                GET_CHK: begin
                    state_d = IDLE;
                    if (i_Rx_Byte == 8'(SYNC_BYTE + addr_q + data_q)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (err_d && (o_Err_Count != 8'hFF)) begin
            err_cnt_d = o_Err_Count + 8'd1;
        end
    end

endmodule
